// File: rtl/dac_update_sched.sv
// dac_update_sched: serialises bias and amplitude words into 24-bit DAC frames.
//
// After SYS_START is seen the block sends one bias and one amplitude frame built from
// BIAS_INIT / AMP_INIT, raises Init_Done, and then serves Bias_Req / Amp_Req with a
// round-robin arbiter. Each frame is {4'b0011, 4'hC, Data[15:0]}, with C = 0 for bias
// and C = 1 for amplitude. The frame is shifted MSB first on DAC_DIN under DAC_SCLK,
// framed by DAC_SYNC_n. The frame is followed by a gap of 2*CLK_DIV cycles.
//
// Ports
//   Clk_100M    in   system clock
//   Rst_n       in   asynchronous active-low reset
//   SYS_START   in   system-start level; dropping it returns to WAIT_START after the
//                    current frame and gap
//   Bias_Req    in   bias update request, held until Bias_Ack
//   Bias_Data   in   bias word, stable while Bias_Req is high
//   Amp_Req     in   amplitude update request, held until Amp_Ack
//   Amp_Data    in   amplitude word, stable while Amp_Req is high
//   Bias_Ack    out  one-cycle grant pulse; the bias word is captured in this cycle
//   Amp_Ack     out  one-cycle grant pulse; the amplitude word is captured in this cycle
//   DAC_SYNC_n  out  frame strobe, active low
//   DAC_SCLK    out  serial clock, idles high
//   DAC_DIN     out  serial data, MSB first, changes only on SCLK falling edges
//   DAC_Busy    out  high from frame load to the end of the gap
//   Init_Done   out  high once both start-up frames have completed
module dac_update_sched #(
  parameter int unsigned CLK_DIV   = 4,
  parameter logic [15:0] BIAS_INIT = 16'h7fff,
  parameter logic [15:0] AMP_INIT  = 16'h7fff
) (
  input  logic        Clk_100M,
  input  logic        Rst_n,
  input  logic        SYS_START,
  input  logic        Bias_Req,
  input  logic [15:0] Bias_Data,
  input  logic        Amp_Req,
  input  logic [15:0] Amp_Data,
  output logic        Bias_Ack,
  output logic        Amp_Ack,
  output logic        DAC_SYNC_n,
  output logic        DAC_SCLK,
  output logic        DAC_DIN,
  output logic        DAC_Busy,
  output logic        Init_Done
);

  // Last divider count of an SCLK half-period.
  localparam logic [7:0] DivLast    = 8'(CLK_DIV - 1);
  localparam logic [4:0] FrameBits  = 5'd24;

  typedef enum logic [2:0] {
    StWaitStart,
    StInitBias,
    StInitAmp,
    StIdle,
    StLoad,
    StShift,
    StGap
  } state_e;

  // Which kind of frame is in flight; decides where the FSM goes when its gap ends.
  typedef enum logic [1:0] {
    FrNormal,
    FrInitBias,
    FrInitAmp
  } frame_kind_e;

  state_e      state_q;
  frame_kind_e kind_q;
  logic [23:0] shreg_q;
  logic [7:0]  div_q;
  logic [4:0]  bit_cnt_q;
  logic        rr_amp_q;  // 1: amplitude wins the next tie
  logic        bias_ack_q;
  logic        amp_ack_q;
  logic        sync_n_q;
  logic        sclk_q;
  logic        din_q;
  logic        busy_q;
  logic        init_done_q;

  function automatic logic [23:0] make_frame(input logic is_amp, input logic [15:0] data);
    return {4'b0011, 3'b000, is_amp, data};
  endfunction

  always_ff @(posedge Clk_100M or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= StWaitStart;
      kind_q      <= FrNormal;
      shreg_q     <= '0;
      div_q       <= '0;
      bit_cnt_q   <= '0;
      rr_amp_q    <= 1'b0;
      bias_ack_q  <= 1'b0;
      amp_ack_q   <= 1'b0;
      sync_n_q    <= 1'b1;
      sclk_q      <= 1'b1;
      din_q       <= 1'b0;
      busy_q      <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      // Acks are single-cycle: only the IDLE grant branch sets them.
      bias_ack_q <= 1'b0;
      amp_ack_q  <= 1'b0;

      unique case (state_q)
        StWaitStart: begin
          if (SYS_START) begin
            state_q  <= StInitBias;
            kind_q   <= FrInitBias;
            shreg_q  <= make_frame(1'b0, BIAS_INIT);
            sync_n_q <= 1'b0;
            busy_q   <= 1'b1;
          end
        end

        // Load-like cycle: the word is already in shreg_q and SYNC is low. The next
        // edge issues the first SCLK fall together with the MSB.
        StInitBias, StInitAmp, StLoad: begin
          state_q   <= StShift;
          sclk_q    <= 1'b0;
          din_q     <= shreg_q[23];
          shreg_q   <= {shreg_q[22:0], 1'b0};
          div_q     <= '0;
          bit_cnt_q <= '0;
        end

        StIdle: begin
          if (!SYS_START) begin
            state_q     <= StWaitStart;
            init_done_q <= 1'b0;
          end else if (Bias_Req && (!Amp_Req || !rr_amp_q)) begin
            state_q    <= StLoad;
            kind_q     <= FrNormal;
            bias_ack_q <= 1'b1;
            shreg_q    <= make_frame(1'b0, Bias_Data);
            sync_n_q   <= 1'b0;
            busy_q     <= 1'b1;
            rr_amp_q   <= 1'b1;
          end else if (Amp_Req) begin
            state_q   <= StLoad;
            kind_q    <= FrNormal;
            amp_ack_q <= 1'b1;
            shreg_q   <= make_frame(1'b1, Amp_Data);
            sync_n_q  <= 1'b0;
            busy_q    <= 1'b1;
            rr_amp_q  <= 1'b0;
          end
        end

        StShift: begin
          if (div_q == DivLast) begin
            div_q <= '0;
            if (!sclk_q) begin
              // Rising edge: the DAC samples the current bit.
              sclk_q    <= 1'b1;
              bit_cnt_q <= bit_cnt_q + 5'd1;
            end else if (bit_cnt_q == FrameBits) begin
              // Last high half-period done; SCLK stays high into the gap.
              state_q   <= StGap;
              sync_n_q  <= 1'b1;
              bit_cnt_q <= '0;
            end else begin
              sclk_q  <= 1'b0;
              din_q   <= shreg_q[23];
              shreg_q <= {shreg_q[22:0], 1'b0};
            end
          end else begin
            div_q <= div_q + 8'd1;
          end
        end

        // The gap is two divider periods; bit_cnt_q counts the first one so the
        // divider itself stays 8 bits wide for any legal CLK_DIV.
        StGap: begin
          if (div_q == DivLast) begin
            div_q <= '0;
            if (bit_cnt_q == 5'd0) begin
              bit_cnt_q <= 5'd1;
            end else begin
              bit_cnt_q <= '0;
              if (!SYS_START) begin
                state_q     <= StWaitStart;
                busy_q      <= 1'b0;
                init_done_q <= 1'b0;
              end else if (kind_q == FrInitBias) begin
                state_q  <= StInitAmp;
                kind_q   <= FrInitAmp;
                shreg_q  <= make_frame(1'b1, AMP_INIT);
                sync_n_q <= 1'b0;
              end else begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
                if (kind_q == FrInitAmp) begin
                  init_done_q <= 1'b1;
                end
              end
            end
          end else begin
            div_q <= div_q + 8'd1;
          end
        end

        default: begin
          state_q <= StWaitStart;
        end
      endcase
    end
  end

  assign Bias_Ack   = bias_ack_q;
  assign Amp_Ack    = amp_ack_q;
  assign DAC_SYNC_n = sync_n_q;
  assign DAC_SCLK   = sclk_q;
  assign DAC_DIN    = din_q;
  assign DAC_Busy   = busy_q;
  assign Init_Done  = init_done_q;

endmodule

// File: tb/tb_dac_update_sched.sv
// tb_dac_update_sched: scoreboard bench for dac_update_sched.
//
// The driver issues requests and pushes the frames it expects (word plus the Ack that
// must accompany it) into exp_q, using a round-robin favour bit as its arbitration
// model. A separate monitor decodes every frame from the serial pins and checks it,
// together with its SCLK count, strobe length and gap length.
module tb_dac_update_sched;

  localparam int unsigned CLK_DIV   = 4;
  localparam logic [15:0] BIAS_INIT = 16'h7fff;
  localparam logic [15:0] AMP_INIT  = 16'h7fff;
  localparam int          FrameLow  = 1 + 48 * CLK_DIV;
  localparam int          GapLen    = 2 * CLK_DIV;
  localparam int          InitLen   = 2 * (1 + 50 * CLK_DIV);

  logic        clk = 1'b0;
  logic        Rst_n;
  logic        SYS_START;
  logic        Bias_Req;
  logic [15:0] Bias_Data;
  logic        Amp_Req;
  logic [15:0] Amp_Data;
  logic        Bias_Ack;
  logic        Amp_Ack;
  logic        DAC_SYNC_n;
  logic        DAC_SCLK;
  logic        DAC_DIN;
  logic        DAC_Busy;
  logic        Init_Done;

  always #5 clk = ~clk;

  dac_update_sched #(
    .CLK_DIV  (CLK_DIV),
    .BIAS_INIT(BIAS_INIT),
    .AMP_INIT (AMP_INIT)
  ) dut (
    .Clk_100M  (clk),
    .Rst_n     (Rst_n),
    .SYS_START (SYS_START),
    .Bias_Req  (Bias_Req),
    .Bias_Data (Bias_Data),
    .Amp_Req   (Amp_Req),
    .Amp_Data  (Amp_Data),
    .Bias_Ack  (Bias_Ack),
    .Amp_Ack   (Amp_Ack),
    .DAC_SYNC_n(DAC_SYNC_n),
    .DAC_SCLK  (DAC_SCLK),
    .DAC_DIN   (DAC_DIN),
    .DAC_Busy  (DAC_Busy),
    .Init_Done (Init_Done)
  );

  typedef struct packed {
    logic [23:0] word;
    logic [1:0]  ack;  // {Bias_Ack, Amp_Ack} seen in the load cycle
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp      = 0;
  int   n_fail     = 0;
  int   stray_acks = 0;
  bit   favour_amp = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: frame layout and who wins the next tie.
  task automatic push_frame(input logic is_amp, input logic [15:0] d, input bit is_init);
    exp_t e;
    e.word = {8'h30 + 8'(is_amp), d};
    e.ack  = is_init ? 2'b00 : (is_amp ? 2'b01 : 2'b10);
    exp_q.push_back(e);
    if (!is_init) favour_amp = !is_amp;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " sync_n"}, 32'(DAC_SYNC_n), 32'd1);
    check({tag, " sclk"},   32'(DAC_SCLK),   32'd1);
    check({tag, " din"},    32'(DAC_DIN),    32'd0);
    check({tag, " acks"},   32'({Bias_Ack, Amp_Ack}), 32'd0);
    check({tag, " busy"},   32'(DAC_Busy),   32'd0);
    check({tag, " done"},   32'(Init_Done),  32'd0);
  endtask

  task automatic wait_idle();
    int quiet = 0;
    int n     = 0;
    while (quiet < 3 && n < 3000) begin
      @(negedge clk);
      n++;
      quiet = DAC_Busy ? 0 : quiet + 1;
    end
    check("idle reached", 32'(quiet >= 3), 32'd1);
  endtask

  // Raise the chosen requests with the DUT idle; drop each one on its Ack.
  task automatic issue(input bit want_b, input bit want_a, input logic [15:0] bd,
                       input logic [15:0] ad);
    logic [1:0] first;
    bit got_b, got_a;
    int waited = 0;
    wait_idle();
    if (want_b && want_a) first = favour_amp ? 2'b01 : 2'b10;
    else                  first = want_b ? 2'b10 : 2'b01;
    if (first == 2'b10) begin
      push_frame(1'b0, bd, 1'b0);
      if (want_a) push_frame(1'b1, ad, 1'b0);
    end else begin
      push_frame(1'b1, ad, 1'b0);
      if (want_b) push_frame(1'b0, bd, 1'b0);
    end
    Bias_Data = bd;
    Amp_Data  = ad;
    Bias_Req  = want_b;
    Amp_Req   = want_a;
    got_b = !want_b;
    got_a = !want_a;
    while (!(got_b && got_a) && waited < 1000) begin
      @(negedge clk);
      waited++;
      if (waited == 1) check("first ack one cycle after request", 32'({Bias_Ack, Amp_Ack}),
                             32'(first));
      if (waited == 2) check("first sclk fall two cycles after request", 32'(DAC_SCLK), 32'd0);
      if (Bias_Ack) begin got_b = 1'b1; Bias_Req = 1'b0; end
      if (Amp_Ack)  begin got_a = 1'b1; Amp_Req  = 1'b0; end
    end
    check("all requests acked", 32'({got_b, got_a}), 32'd3);
  endtask

  // Amp_Req raised in WAIT_START, then SYS_START: two init frames, then the amp frame.
  task automatic start_with_pending_amp(input logic [15:0] ad);
    int n = 0;
    int early = 0;
    bit got = 1'b0;
    wait_idle();
    push_frame(1'b0, BIAS_INIT, 1'b1);
    push_frame(1'b1, AMP_INIT, 1'b1);
    push_frame(1'b1, ad, 1'b0);
    Amp_Data = ad;
    Amp_Req  = 1'b1;
    repeat (10) begin @(negedge clk); if (Amp_Ack) early++; end
    SYS_START = 1'b1;
    while (DAC_SYNC_n && n < 100) begin @(negedge clk); n++; if (Amp_Ack) early++; end
    check("init frame started", 32'(DAC_SYNC_n), 32'd0);
    n = 0;
    while (!Init_Done && n < 2000) begin @(negedge clk); n++; if (Amp_Ack) early++; end
    check("init_done after first sync fall", 32'(n), 32'(InitLen));
    check("no ack before init_done", 32'(early), 32'd0);
    n = 0;
    while (!got && n < 50) begin
      @(negedge clk);
      n++;
      if (Amp_Ack) begin got = 1'b1; Amp_Req = 1'b0; end
    end
    check("pending amp ack cycles after init_done", 32'(n), 32'd1);
  endtask

  // Monitor: decode frames from the pins and compare against exp_q.
  initial begin
    bit          in_frame   = 1'b0;
    bit          gap_active = 1'b0;
    logic        sync_prev  = 1'b1;
    logic        sclk_prev  = 1'b1;
    logic        din_prev   = 1'b0;
    logic [23:0] word       = '0;
    logic [1:0]  ack_seen   = '0;
    int          rises = 0, falls = 0, low_cycles = 0, din_bad = 0, gap_cnt = 0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!Rst_n) begin
        in_frame   = 1'b0;
        gap_active = 1'b0;
        sync_prev  = 1'b1;
        sclk_prev  = 1'b1;
        din_prev   = 1'b0;
      end else begin
        bit fall, rise, starting;
        fall     = sclk_prev && !DAC_SCLK;
        rise     = !sclk_prev && DAC_SCLK;
        starting = !in_frame && sync_prev && !DAC_SYNC_n;
        if ((Bias_Ack || Amp_Ack) && !starting) stray_acks++;
        if (gap_active) begin
          if (DAC_Busy && DAC_SYNC_n) gap_cnt++;
          else begin
            check("gap length", 32'(gap_cnt), 32'(GapLen));
            gap_active = 1'b0;
          end
        end
        if (in_frame) begin
          if (!DAC_SYNC_n) begin
            low_cycles++;
            if (fall) falls++;
            if (rise) begin word = {word[22:0], DAC_DIN}; rises++; end
            if (DAC_DIN !== din_prev && !fall) din_bad++;
          end else begin
            in_frame   = 1'b0;
            gap_active = 1'b1;
            gap_cnt    = 1;
            check("frame was expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              check("frame word", 32'(word), 32'(e.word));
              check("frame ack", 32'(ack_seen), 32'(e.ack));
            end
            check("sclk falls per frame", 32'(falls), 32'd24);
            check("sclk rises per frame", 32'(rises), 32'd24);
            check("sync low cycles", 32'(low_cycles), 32'(FrameLow));
            check("din changes off sclk fall", 32'(din_bad), 32'd0);
            check("busy at gap start", 32'(DAC_Busy), 32'd1);
          end
        end else if (starting) begin
          in_frame   = 1'b1;
          word       = '0;
          rises      = 0;
          falls      = 0;
          din_bad    = 0;
          low_cycles = 1;
          ack_seen   = {Bias_Ack, Amp_Ack};
        end
        sync_prev = DAC_SYNC_n;
        sclk_prev = DAC_SCLK;
        din_prev  = DAC_DIN;
      end
    end
  end

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation exceeded time limit, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    int pat;
    logic [15:0] d;
    Rst_n     = 1'b0;
    SYS_START = 1'b0;
    Bias_Req  = 1'b0;
    Amp_Req   = 1'b0;
    Bias_Data = '0;
    Amp_Data  = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("power-on reset");
    Rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle before SYS_START", 32'({DAC_Busy, DAC_SYNC_n}), 32'b01);

    // Start-up with an early amplitude request.
    start_with_pending_amp(16'($urandom));

    // Directed single bias request.
    issue(1'b1, 1'b0, 16'h1234, 16'h0000);

    // Randomised requests: bias only, amp only, or both together.
    for (int i = 0; i < 12; i++) begin
      pat = int'($urandom_range(0, 2));
      issue(pat != 1, pat != 0, 16'($urandom), 16'($urandom));
    end

    // Both requests held through four frames: must alternate.
    wait_idle();
    Bias_Data = 16'($urandom);
    Amp_Data  = 16'($urandom);
    for (int i = 0; i < 4; i++) begin
      if (favour_amp) push_frame(1'b1, Amp_Data, 1'b0);
      else            push_frame(1'b0, Bias_Data, 1'b0);
    end
    Bias_Req = 1'b1;
    Amp_Req  = 1'b1;
    acks = 0;
    for (int n = 0; n < 3000 && acks < 4; n++) begin
      @(negedge clk);
      if (Bias_Ack) acks++;
      if (Amp_Ack)  acks++;
    end
    Bias_Req = 1'b0;
    Amp_Req  = 1'b0;
    check("contention acks", 32'(acks), 32'd4);

    // SYS_START drops mid-frame: frame completes, then back to WAIT_START.
    issue(1'b1, 1'b0, 16'($urandom), 16'h0000);
    repeat (20) @(negedge clk);
    SYS_START = 1'b0;
    wait_idle();
    check("init_done low after stop", 32'(Init_Done), 32'd0);
    d = 16'($urandom);
    Amp_Data = d;
    Amp_Req  = 1'b1;
    acks = 0;
    repeat (100) begin @(negedge clk); if (Amp_Ack) acks++; end
    check("no ack while stopped", 32'(acks), 32'd0);
    start_with_pending_amp(d);

    // Reset in the middle of SHIFT.
    issue(1'b1, 1'b0, 16'($urandom), 16'h0000);
    repeat (30) @(negedge clk);
    @(posedge clk);
    #2;
    Rst_n     = 1'b0;
    SYS_START = 1'b0;
    Bias_Req  = 1'b1;
    #1;
    check_reset_outputs("mid-shift reset");
    exp_q.delete(0);
    favour_amp = 1'b0;
    #20;
    Rst_n = 1'b1;
    acks = 0;
    repeat (50) begin @(negedge clk); if (Bias_Ack || Amp_Ack) acks++; end
    check("no ack after reset", 32'(acks), 32'd0);
    Bias_Req = 1'b0;
    start_with_pending_amp(16'($urandom));
    for (int i = 0; i < 3; i++) begin
      pat = int'($urandom_range(0, 2));
      issue(pat != 1, pat != 0, 16'($urandom), 16'($urandom));
    end
    wait_idle();
    repeat (5) @(negedge clk);
    check("all expected frames seen", 32'(exp_q.size()), 32'd0);
    check("acks outside load cycles", 32'(stray_acks), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
